// File: rtl/irq_button_ctrl_if.sv
// Button/interrupt bundle between irq_button_ctrl (master) and the pipeline/board side (slave).
// Carries the raw button, the trap handshake and the status outputs.
interface irq_button_ctrl_if #(
  parameter int PEND_W = 4
);
  logic              btn;
  logic              irq_ack;
  logic              irq_ret;
  logic              irq_req;
  logic              iled;
  logic              btn1;
  logic [PEND_W-1:0] pend_cnt;

  modport master (
    input  btn, irq_ack, irq_ret,
    output irq_req, iled, btn1, pend_cnt
  );

  modport slave (
    output btn, irq_ack, irq_ret,
    input  irq_req, iled, btn1, pend_cnt
  );
endinterface

// File: rtl/irq_button_ctrl.sv
// Button front end for the RV32 external interrupt: sync, debounce, press -> request FSM, press queue.
// Optional IRQ_ASYNC_CAPTURE_EN: latch sub-cycle button pulses with a btn-clocked capture flop.
module irq_button_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PEND_W          = 4
) (
  input logic               clk,
  input logic               reset,
  irq_button_ctrl_if.master bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  logic                   btn_in;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic [DB_W-1:0]        db_cnt;
  logic                   btn1_q;
  logic                   btn1_d;
  logic                   press;
  state_t                 state, state_nxt;
  logic [PEND_W-1:0]      pend_q, pend_nxt;
  logic                   pend_inc;
  logic                   irq_req_q;
  logic                   iled_q;

`ifdef IRQ_ASYNC_CAPTURE_EN
  logic cap_q;
  logic cap_clr;

  // Raw button edge is the clock: any pulse, however short, sets the flop.
  always_ff @(posedge bus.btn or posedge reset or posedge cap_clr) begin
    if (reset || cap_clr) cap_q <= 1'b0;
    else                  cap_q <= 1'b1;
  end

  // Release the capture once the debounced level has seen it and the button is let go.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cap_clr <= 1'b0;
    else       cap_clr <= ~cap_clr & cap_q & btn1_q & btn_s & ~bus.btn;
  end

  assign btn_in = cap_q;
`else
  assign btn_in = bus.btn;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      btn1_q <= 1'b0;
      btn1_d <= 1'b0;
    end else begin
      btn1_d <= btn1_q;
      if (btn_s == btn1_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn1_q <= ~btn1_q;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = btn1_q & ~btn1_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pend_q    <= '0;
      irq_req_q <= 1'b0;
      iled_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend_q    <= pend_nxt;
      irq_req_q <= (state_nxt == REQ);
      iled_q    <= (state_nxt == SERVICE);
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_q;
    pend_inc  = press && (pend_q != PEND_MAX);
    case (state)
      IDLE: begin
        if (press) state_nxt = REQ;
      end
      REQ: begin
        if (bus.irq_ack) state_nxt = SERVICE;
        if (pend_inc)    pend_nxt  = pend_q + 1'b1;
      end
      SERVICE: begin
        if (bus.irq_ret) begin
          // A press landing with the return either replaces the popped entry or is served directly.
          state_nxt = ((pend_q != '0) || press) ? REQ : IDLE;
          if ((pend_q != '0) && !press) pend_nxt = pend_q - 1'b1;
        end else if (pend_inc) begin
          pend_nxt = pend_q + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.irq_req  = irq_req_q;
  assign bus.iled     = iled_q;
  assign bus.btn1     = btn1_q;
  assign bus.pend_cnt = pend_q;

endmodule
